// File: rtl/mp_link_ctrl.sv
// Link-level controller for the two-board game: exchanges 'R' (ready) and 'L' (loser)
// bytes with the peer board and turns them into start / win / lose status for the game FSM.
module mp_link_ctrl #(
    parameter int BEACON_PERIOD = 1_000_000,
    parameter int L_REPEAT      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       multiplayer,
    input  logic       player_ready,
    input  logic       game_over,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       tx_full,
    output logic [7:0] tx_data,
    output logic       tx_wr,
    output logic       game_start,
    output logic       victory,
    output logic       defeat,
    output logic       waiting,
    output logic [2:0] state
);

    localparam int BW = $clog2(BEACON_PERIOD);
    localparam int RW = $clog2(L_REPEAT + 1);
    localparam logic [BW-1:0] TERM       = BW'(BEACON_PERIOD - 1);
    localparam logic [RW-1:0] REP_INIT   = RW'(L_REPEAT);
    localparam logic [7:0]    BYTE_READY = 8'h52;
    localparam logic [7:0]    BYTE_LOSER = 8'h4C;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_PEER = 3'd1,
        PLAYING   = 3'd2,
        WON       = 3'd3,
        LOST      = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] beacon_cnt, beacon_cnt_d;
    logic [RW-1:0] rep_cnt, rep_cnt_d;
    logic          peer_seen, peer_seen_d;
    logic          echo_pend, echo_pend_d;
    logic          ready_prev;
    logic          send;
    logic [7:0]    send_byte;
    logic          rx_ready, rx_loser, ready_rise, term;

    assign rx_ready   = rx_valid && (rx_data == BYTE_READY);
    assign rx_loser   = rx_valid && (rx_data == BYTE_LOSER);
    assign ready_rise = player_ready && !ready_prev;
    assign term       = (beacon_cnt == TERM);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            beacon_cnt <= '0;
            rep_cnt    <= '0;
            peer_seen  <= 1'b0;
            echo_pend  <= 1'b0;
            ready_prev <= 1'b0;
            tx_wr      <= 1'b0;
            tx_data    <= 8'h00;
            game_start <= 1'b0;
        end else begin
            state_q    <= state_d;
            beacon_cnt <= beacon_cnt_d;
            rep_cnt    <= rep_cnt_d;
            peer_seen  <= peer_seen_d;
            echo_pend  <= echo_pend_d;
            ready_prev <= player_ready;
            tx_wr      <= send;
            if (send)
                tx_data <= send_byte;
            game_start <= (state_d == PLAYING) && (state_q != PLAYING);
        end
    end

    always_comb begin
        state_d = state_q;
        if (!multiplayer) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:      if (player_ready) state_d = WAIT_PEER;
                WAIT_PEER: begin
                    if (!player_ready)              state_d = IDLE;
                    else if (peer_seen || rx_ready) state_d = PLAYING;
                end
                PLAYING: begin
                    if (game_over)     state_d = LOST;
                    else if (rx_loser) state_d = WON;
                end
                WON, LOST: if (ready_rise) state_d = WAIT_PEER;
                default:   state_d = IDLE;
            endcase
        end
    end

    // Transmit only while the state is stable; leaving a state abandons its pending byte.
    always_comb begin
        send      = 1'b0;
        send_byte = 8'h00;
        if (multiplayer && (state_d == state_q) && !tx_full) begin
            case (state_q)
                WAIT_PEER: if (term) begin
                    send      = 1'b1;
                    send_byte = BYTE_READY;
                end
                PLAYING: if (echo_pend) begin
                    send      = 1'b1;
                    send_byte = BYTE_READY;
                end
                LOST: if ((rep_cnt != '0) && ((rep_cnt == REP_INIT) || term)) begin
                    send      = 1'b1;
                    send_byte = BYTE_LOSER;
                end
                default: ;
            endcase
        end
    end

    // Counter restarts after each send so 'L' repeats keep a full period from the first one.
    always_comb begin
        beacon_cnt_d = beacon_cnt;
        if ((state_d != state_q) || !((state_q == WAIT_PEER) || (state_q == LOST)))
            beacon_cnt_d = '0;
        else if (send)
            beacon_cnt_d = '0;
        else if (!term)
            beacon_cnt_d = beacon_cnt + BW'(1);

        rep_cnt_d = rep_cnt;
        if (state_d != LOST)
            rep_cnt_d = '0;
        else if (state_q != LOST)
            rep_cnt_d = REP_INIT;
        else if (send)
            rep_cnt_d = rep_cnt - RW'(1);

        peer_seen_d = peer_seen;
        if (!multiplayer || (state_d == PLAYING) || ((state_d == IDLE) && (state_q != IDLE)))
            peer_seen_d = 1'b0;
        else if (rx_ready && ((state_q == IDLE) || (state_q == WAIT_PEER)))
            peer_seen_d = 1'b1;

        echo_pend_d = 1'b0;
        if ((state_q == PLAYING) && (state_d == PLAYING))
            echo_pend_d = (echo_pend && !send) || rx_ready;
    end

    assign state   = state_q;
    assign waiting = (state_q == WAIT_PEER);
    assign victory = (state_q == WON);
    assign defeat  = (state_q == LOST);

endmodule

// File: tb/tb_mp_link_ctrl.sv
// Directed self-checking bench for mp_link_ctrl with BEACON_PERIOD=8, L_REPEAT=3.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mp_link_ctrl;

    logic       clk;
    logic       rst;
    logic       multiplayer;
    logic       player_ready;
    logic       game_over;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_full;
    logic [7:0] tx_data;
    logic       tx_wr;
    logic       game_start;
    logic       victory;
    logic       defeat;
    logic       waiting;
    logic [2:0] state;

    logic [15:0] outvec;
    int checks_total  = 0;
    int checks_passed = 0;
    int tx_count      = 0;

    mp_link_ctrl #(
        .BEACON_PERIOD(8),
        .L_REPEAT(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .multiplayer(multiplayer),
        .player_ready(player_ready),
        .game_over(game_over),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .tx_full(tx_full),
        .tx_data(tx_data),
        .tx_wr(tx_wr),
        .game_start(game_start),
        .victory(victory),
        .defeat(defeat),
        .waiting(waiting),
        .state(state)
    );

    assign outvec = {tx_data, tx_wr, game_start, victory, defeat, waiting, state};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(negedge clk);
        if (tx_wr)
            tx_count++;
    endtask

    task automatic applyStimulus(input logic mp, input logic ready, input logic go, input logic full);
        multiplayer  = mp;
        player_ready = ready;
        game_over    = go;
        tx_full      = full;
    endtask

    task automatic pulseRx(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks_total++;
        assert (observed === expected) checks_passed++;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    endtask

    // Ticks until tx_wr is seen; cycles = number of ticks taken, or -1 on timeout.
    task automatic waitTx(input int limit, output int cycles);
        cycles = -1;
        for (int i = 1; i <= limit; i++) begin
            tick();
            if (tx_wr) begin
                cycles = i;
                break;
            end
        end
    endtask

    initial begin
        int n;
        int c0;
        logic [15:0] acc;

        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        applyStimulus(0, 0, 0, 0);
        repeat (3) tick();
        checkOutput("reset_outputs", outvec, 0);

        rst = 1'b0;
        applyStimulus(1, 0, 0, 0);
        acc = '0;
        c0  = tx_count;
        repeat (50) begin
            tick();
            acc |= outvec;
        end
        checkOutput("idle_quiet", acc, 0);
        checkOutput("idle_no_tx", tx_count - c0, 0);

        applyStimulus(1, 1, 0, 0);
        tick();
        checkOutput("wait_state", state, 1);
        checkOutput("waiting_flag", waiting, 1);
        waitTx(20, n);
        checkOutput("first_beacon_delay", n, 8);
        checkOutput("beacon_byte", tx_data, 8'h52);
        waitTx(20, n);
        checkOutput("beacon_period", n, 8);

        applyStimulus(1, 1, 0, 1);
        c0 = tx_count;
        repeat (20) tick();
        checkOutput("full_blocks_tx", tx_count - c0, 0);
        applyStimulus(1, 1, 0, 0);
        waitTx(20, n);
        checkOutput("retry_after_full", n, 1);
        checkOutput("retry_byte", tx_data, 8'h52);

        pulseRx(8'h4C);
        checkOutput("wait_ignores_L", state, 1);
        pulseRx(8'h00);
        checkOutput("wait_ignores_other", state, 1);

        pulseRx(8'h52);
        checkOutput("start_state", state, 2);
        checkOutput("start_pulse", game_start, 1);
        tick();
        checkOutput("start_pulse_end", game_start, 0);
        checkOutput("playing_waiting_low", waiting, 0);

        pulseRx(8'h52);
        waitTx(10, n);
        checkOutput("echo_delay", n, 1);
        checkOutput("echo_byte", tx_data, 8'h52);
        c0 = tx_count;
        repeat (10) tick();
        checkOutput("echo_single", tx_count - c0, 0);

        c0       = tx_count;
        rx_valid = 1'b1;
        rx_data  = 8'h52;
        tick();
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (10) tick();
        checkOutput("echo_two", tx_count - c0, 2);
        pulseRx(8'h41);
        checkOutput("playing_ignores_other", state, 2);

        applyStimulus(1, 1, 1, 0);
        tick();
        checkOutput("lost_state", state, 4);
        checkOutput("lost_defeat", defeat, 1);
        waitTx(10, n);
        checkOutput("first_L_delay", n, 1);
        checkOutput("L_byte", tx_data, 8'h4C);
        waitTx(20, n);
        checkOutput("second_L_spacing", n, 8);
        waitTx(20, n);
        checkOutput("third_L_spacing", n, 8);
        checkOutput("third_L_byte", tx_data, 8'h4C);
        c0 = tx_count;
        repeat (100) tick();
        checkOutput("L_silence", tx_count - c0, 0);
        checkOutput("lost_defeat_held", defeat, 1);

        applyStimulus(1, 0, 0, 0);
        tick();
        checkOutput("lost_ready_drop_stays", state, 4);
        applyStimulus(1, 1, 0, 0);
        tick();
        checkOutput("lost_rise_to_wait", state, 1);

        pulseRx(8'h52);
        checkOutput("restart_playing", state, 2);
        pulseRx(8'h4C);
        checkOutput("won_state", state, 3);
        checkOutput("won_victory", victory, 1);
        c0 = tx_count;
        repeat (20) tick();
        checkOutput("won_silent", tx_count - c0, 0);

        applyStimulus(1, 0, 0, 0);
        tick();
        applyStimulus(1, 1, 0, 0);
        tick();
        checkOutput("won_rise_to_wait", state, 1);
        waitTx(20, n);
        checkOutput("beacon_resume", n, 8);
        checkOutput("beacon_resume_byte", tx_data, 8'h52);

        pulseRx(8'h52);
        checkOutput("prio_playing", state, 2);
        applyStimulus(1, 1, 1, 0);
        pulseRx(8'h4C);
        checkOutput("prio_lost", state, 4);
        checkOutput("prio_no_victory", victory, 0);

        waitTx(10, n);
        checkOutput("abort_first_L", n, 1);
        applyStimulus(0, 1, 0, 0);
        tick();
        checkOutput("abort_idle", state, 0);
        checkOutput("abort_defeat_low", defeat, 0);
        c0 = tx_count;
        repeat (30) tick();
        checkOutput("abort_no_tx", tx_count - c0, 0);

        applyStimulus(1, 0, 0, 0);
        tick();
        pulseRx(8'h52);
        checkOutput("early_R_idle", state, 0);
        applyStimulus(1, 1, 0, 0);
        tick();
        checkOutput("early_R_wait", state, 1);
        tick();
        checkOutput("early_R_playing", state, 2);
        checkOutput("early_R_start", game_start, 1);

        rst = 1'b1;
        tick();
        checkOutput("midrun_reset", outvec, 0);
        rst = 1'b0;
        tick();

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
